// File: rtl/median_pkg.sv
// ---------------------------------------------------------------------------
// median_pkg
// Shared definitions for the 3x3 median collector: default pixel width,
// window geometry, FSM state encoding and the window-slot index helpers.
// ---------------------------------------------------------------------------
package median_pkg;

    localparam int          PIX_W_DEF  = 8;
    localparam int          WIN_SIZE   = 9;
    localparam int          MEDIAN_IDX = 4;
    localparam logic [8:0]  FULL_MASK  = 9'h1FF;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SORT    = 2'd1,
        EMIT    = 2'd2
    } state_t;

    // 2'b10 (-2) is outside the -1..1 window and never addresses a slot.
    function automatic logic offset_legal(input logic [1:0] offset);
        return offset != 2'b10;
    endfunction

    // Slot index (y+1)*3 + (x+1), evaluated in 4-bit unsigned after
    // sign-extension so that -1 maps to column/row 0.
    function automatic logic [3:0] slot_index(input logic [1:0] x, input logic [1:0] y);
        logic [3:0] xe;
        logic [3:0] ye;
        xe = {{2{x[1]}}, x} + 4'd1;
        ye = {{2{y[1]}}, y} + 4'd1;
        return ye * 4'd3 + xe;
    endfunction

endpackage

// File: rtl/offset_delay.sv
// ---------------------------------------------------------------------------
// offset_delay
// READ_LAT-deep shift register aligning the window offset stream with the
// pixel RAM read data.
//   clk, reset          : clock, synchronous active-high reset (clears valid)
//   windowValid         : offset stream valid from the window counter
//   countX, countY      : signed 2-bit column/row offsets
//   vD, xD, yD          : the same triple delayed by READ_LAT cycles
// ---------------------------------------------------------------------------
module offset_delay #(
    parameter int READ_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       windowValid,
    input  logic [1:0] countX,
    input  logic [1:0] countY,
    output logic       vD,
    output logic [1:0] xD,
    output logic [1:0] yD
);

    logic [READ_LAT-1:0] v_pipe;
    logic [1:0]          x_pipe [READ_LAT];
    logic [1:0]          y_pipe [READ_LAT];

    // NOTE: sequential state is always assigned with <= so every stage
    // samples the value its neighbour held before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_pipe <= '0;
        end else begin
            v_pipe[0] <= windowValid;
            for (int i = 1; i < READ_LAT; i++) begin
                v_pipe[i] <= v_pipe[i-1];
            end
        end
    end

    // NOTE: offset payload needs no reset; it is only consumed while the
    // reset-cleared valid bit travelling beside it is high.
    always_ff @(posedge clk) begin
        x_pipe[0] <= countX;
        y_pipe[0] <= countY;
        for (int i = 1; i < READ_LAT; i++) begin
            x_pipe[i] <= x_pipe[i-1];
            y_pipe[i] <= y_pipe[i-1];
        end
    end

    assign vD = v_pipe[READ_LAT-1];
    assign xD = x_pipe[READ_LAT-1];
    assign yD = y_pipe[READ_LAT-1];

endmodule

// File: rtl/window_median_collector.sv
// ---------------------------------------------------------------------------
// window_median_collector
// Pairs returned pixels with their 3x3 window slot, and once all nine slots
// are filled runs a 9-phase odd-even transposition sort and emits the median.
//   clk, reset   : clock, synchronous active-high reset
//   windowValid  : offset stream valid (undelayed, from the window counter)
//   countX/Y     : signed column/row offsets, -1..1
//   pixelIn      : RAM read data, valid READ_LAT cycles after its address
//   medianOut    : median of the last completed window, held between results
//   medianValid  : one-cycle pulse when medianOut updates
//   busy         : high while sorting or emitting
//   overrun      : sticky, a sample arrived while busy and was dropped
// ---------------------------------------------------------------------------
module window_median_collector
    import median_pkg::*;
#(
    parameter int PIX_W    = PIX_W_DEF,
    parameter int READ_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             windowValid,
    input  logic [1:0]       countX,
    input  logic [1:0]       countY,
    input  logic [PIX_W-1:0] pixelIn,
    output logic [PIX_W-1:0] medianOut,
    output logic             medianValid,
    output logic             busy,
    output logic             overrun
);

    logic       vD;
    logic [1:0] xD;
    logic [1:0] yD;

    offset_delay #(.READ_LAT(READ_LAT)) u_offset_delay (
        .clk         (clk),
        .reset       (reset),
        .windowValid (windowValid),
        .countX      (countX),
        .countY      (countY),
        .vD          (vD),
        .xD          (xD),
        .yD          (yD)
    );

    state_t           state;
    state_t           state_next;
    logic [8:0]       mask;
    logic [3:0]       phase;
    logic             vd_prev;
    logic [PIX_W-1:0] s        [WIN_SIZE];
    logic [PIX_W-1:0] s_sorted [WIN_SIZE];

    logic [3:0] idx;
    logic [8:0] hit;
    logic       sample_ok;
    logic       window_done;

    assign idx         = slot_index(xD, yD);
    assign hit         = 9'b1 << idx;
    assign sample_ok   = vD && offset_legal(xD) && offset_legal(yD);
    assign window_done = sample_ok && ((mask | hit) == FULL_MASK);
    assign busy        = (state != COLLECT);

    // One transposition phase: even phases pair (0,1)..(6,7), odd phases
    // pair (1,2)..(7,8). Pairs are disjoint, so all swaps read the old array.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        s_sorted = s;
        for (int i = 0; i < WIN_SIZE - 1; i++) begin
            if (((i % 2) == 1) == phase[0] && s[i] > s[i+1]) begin
                s_sorted[i]   = s[i+1];
                s_sorted[i+1] = s[i];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (window_done)  state_next = SORT;
            SORT:    if (phase == 4'd8) state_next = EMIT;
            EMIT:    state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= COLLECT;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask        <= '0;
            phase       <= '0;
            vd_prev     <= 1'b0;
            medianOut   <= '0;
            medianValid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            vd_prev     <= vD;
            medianValid <= 1'b0;
            case (state)
                COLLECT: begin
                    if (window_done) begin
                        mask  <= FULL_MASK;
                        phase <= '0;
                    end else if (sample_ok) begin
                        mask <= mask | hit;
                    end else if (vd_prev && !vD) begin
                        // Stream ended before the window filled: discard it.
                        mask <= '0;
                    end
                end
                SORT: phase <= phase + 4'd1;
                EMIT: begin
                    medianOut   <= s[MEDIAN_IDX];
                    medianValid <= 1'b1;
                    mask        <= '0;
                end
                default: mask <= '0;
            endcase
            if (busy && vD) overrun <= 1'b1;
        end
    end

    // Slot storage has no reset: a slot is only read after the mask shows
    // it was written in the current window.
    always_ff @(posedge clk) begin
        if (state == COLLECT && sample_ok) begin
            s[idx] <= pixelIn;
        end else if (state == SORT) begin
            s <= s_sorted;
        end
    end

endmodule
